record_playback_seq: RTL and testbench
======================================

Name: record_playback_seq

Overview:
- Parametrised successor to the single-channel key recorder.
- Samples CHANNELS key lines into on-chip memory at a programmable tick rate.
- Records up to DEPTH steps, then plays the recorded length back once or looping, with stop/overflow/done status.
- Sits between the debounced KEY inputs and the note/LED/HEX output stage of the MIDI-Fighter top.

Parameters:
CHANNELS, 4, number of key/note channels recorded per step
DEPTH, 128, number of steps in sample memory (power of two)
TICK_DIV, 12500000, CLOCK_50 cycles per step (12500000 = 0.25 s); must be >= 2
ADDR_W, $clog2(DEPTH), address width (derived, not overridden)

Ports:
CLOCK_50  input  1  system clock; only clock in the block
reset  input  1  synchronous, active-high reset
keys_n  input  CHANNELS  key lines, active-low (pressed = 0)
rec_start  input  1  level-sampled each cycle; starts recording from IDLE
play_start  input  1  level-sampled each cycle; starts playback from IDLE
stop  input  1  aborts RECORD or PLAY, returns to IDLE
loop_en  input  1  1 = playback wraps to step 0 at end of recording
notes_out  output  CHANNELS  active-high played notes; 0 unless PLAY
address  output  ADDR_W  current record/play step
length  output  ADDR_W+1  number of valid recorded steps
recording  output  1  high in RECORD
playing  output  1  high in PLAY
done  output  1  high in IDLE once length > 0
overflow  output  1  sticky: last recording filled DEPTH

Behaviour:
- Reset (CLOCK_50 edge with reset=1):
  - state=IDLE; address=0; length=0; notes_out=0; overflow=0; divider=0.
  - Memory contents are not cleared; length=0 makes them invalid.
- Divider:
  - Counts 0..TICK_DIV-1 only in RECORD/PLAY; tick = one-cycle pulse when count==TICK_DIV-1.
  - Cleared on every state entry, so the first tick is exactly TICK_DIV cycles after entry.
- Command priority each cycle: stop > rec_start > play_start. Starts are ignored outside IDLE.
- IDLE -> RECORD on rec_start:
  - address=0, length=0, overflow=0.
  - The first sample is written on entry: mem[0] <= ~keys_n.
- RECORD, on each tick:
  - address++; mem[address+1] <= ~keys_n; length = address+1.
  - The entry write counts as length 1.
  - When the write to DEPTH-1 is done: length=DEPTH, overflow=1, go to IDLE.
- RECORD, on stop: go to IDLE and keep length (steps written so far, >=1).
- IDLE -> PLAY on play_start with length>0:
  - address=0.
  - play_start with length==0 is ignored and the block stays IDLE.
- PLAY:
  - Synchronous-read memory: notes_out = mem[address] with 1-cycle latency, valid from the 2nd cycle in PLAY.
  - On tick with address < length-1: address++.
  - On tick with address == length-1:
    - loop_en=1: address=0 and stay in PLAY.
    - loop_en=0: go to IDLE, address=0, notes_out=0 on the next cycle.
  - loop_en is sampled only at that tick.
- PLAY, on stop: IDLE, notes_out=0, address=0.
- Output decode:
  - recording/playing/done decode the registered state; done = (state==IDLE) && (length!=0).
  - length=DEPTH needs ADDR_W+1 bits; address wraps only by explicit reset to 0, never by overflow.
- reset asserted mid-RECORD or mid-PLAY: the reset values above apply on that edge and override all commands.

Decomposition:
- Package rps_pkg holds:
  - state enum (IDLE, RECORD, PLAY; 2-bit);
  - localparam helper for ADDR_W;
  - default TICK_DIV constant.
- Sub-module tick_divider (parameter TICK_DIV; ports CLOCK_50, clear, en, tick) provides the step pulse.
- Sample memory is an inferred sync-read RAM inside record_playback_seq, with no separate module.

Test Plan:
Bench parameters: CHANNELS=4, DEPTH=8, TICK_DIV=4.
1. reset=1 for 2 cycles -> address=0, length=0, notes_out=0, done=0, overflow=0, recording=playing=0.
2. rec_start, keys_n sequence 1110,1101,1011, then stop after 2 ticks -> length=3, done=1; play_start with loop_en=0 -> notes_out 0001,0010,0100 for 4 cycles each, then IDLE, notes_out=0.
3. Record without stop -> after 7 ticks length=8, overflow=1, state IDLE; a new rec_start -> overflow=0.
4. length=3 with loop_en=1 -> address cycles 0,1,2,0,1,...; stop asserted mid-step -> IDLE next edge, notes_out=0.
5. play_start while length=0 -> stays IDLE, playing=0; rec_start and play_start together in IDLE -> RECORD.
6. reset asserted during PLAY at address=2 -> next edge address=0, length=0, playing=0, notes_out=0.

Source files
------------

// File: rtl/rps_pkg.sv
// Shared types and constants for the record/playback sequencer.
package rps_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECORD = 2'd1,
        ST_PLAY   = 2'd2
    } state_t;

    // 0.25 s per step at 50 MHz
    localparam int unsigned DEFAULT_TICK_DIV = 12500000;

    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/record_playback_seq_tick_divider.sv
// Step-rate divider: one-cycle tick every TICK_DIV enabled cycles after a clear.
module tick_divider
    import rps_pkg::*;
#(
    parameter int unsigned TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic CLOCK_50,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] count;

    // tick is registered one count early so it is high while count == TICK_DIV-1
    always_ff @(posedge CLOCK_50) begin
        if (clear) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (en) begin
            count <= (count == CNT_W'(TICK_DIV - 1)) ? '0 : count + CNT_W'(1);
            tick  <= (count == CNT_W'(TICK_DIV - 2));
        end
    end

endmodule

// File: rtl/record_playback_seq.sv
// Multi-channel key recorder: samples keys into RAM at a step rate and plays
// the recorded length back once or looping.
module record_playback_seq
    import rps_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DEPTH    = 128,
    parameter int unsigned TICK_DIV = DEFAULT_TICK_DIV,
    parameter int unsigned ADDR_W   = addr_width(DEPTH)
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic [CHANNELS-1:0] keys_n,
    input  logic                rec_start,
    input  logic                play_start,
    input  logic                stop,
    input  logic                loop_en,
    output logic [CHANNELS-1:0] notes_out,
    output logic [ADDR_W-1:0]   address,
    output logic [ADDR_W:0]     length,
    output logic                recording,
    output logic                playing,
    output logic                done,
    output logic                overflow
);

    localparam int unsigned LEN_W = ADDR_W + 1;

    state_t              state;
    state_t              state_nxt;
    logic                tick;
    logic                div_clear;
    logic                div_en;
    logic                last_rec;
    logic                last_play;
    logic                has_data;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [LEN_W-1:0]    len_nxt;
    logic                ovf_nxt;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic                notes_keep;

    logic [CHANNELS-1:0] mem [DEPTH];

    assign has_data  = (length != '0);
    assign last_rec  = (address == ADDR_W'(DEPTH - 2));
    assign last_play = ({1'b0, address} == length - LEN_W'(1));
    assign div_en    = (state == ST_RECORD) || (state == ST_PLAY);
    assign div_clear = reset || (state_nxt != state);

    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_divider (
        .CLOCK_50 (CLOCK_50),
        .clear    (div_clear),
        .en       (div_en),
        .tick     (tick)
    );

    always_ff @(posedge CLOCK_50) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Command priority: stop > rec_start > play_start; starts only act in IDLE
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (!stop) begin
                    if (rec_start)                 state_nxt = ST_RECORD;
                    else if (play_start && has_data) state_nxt = ST_PLAY;
                end
            end
            ST_RECORD: if (stop || (tick && last_rec))             state_nxt = ST_IDLE;
            ST_PLAY:   if (stop || (tick && last_play && !loop_en)) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        addr_nxt   = address;
        len_nxt    = length;
        ovf_nxt    = overflow;
        mem_we     = 1'b0;
        mem_waddr  = '0;
        notes_keep = (state == ST_PLAY) && (state_nxt == ST_PLAY);
        unique case (state)
            ST_IDLE: begin
                if (state_nxt == ST_RECORD) begin
                    addr_nxt = '0;
                    len_nxt  = LEN_W'(1);
                    ovf_nxt  = 1'b0;
                    mem_we   = 1'b1;
                end else if (state_nxt == ST_PLAY) begin
                    addr_nxt = '0;
                end
            end
            ST_RECORD: begin
                if (!stop && tick) begin
                    addr_nxt  = address + ADDR_W'(1);
                    mem_we    = 1'b1;
                    mem_waddr = address + ADDR_W'(1);
                    len_nxt   = {1'b0, address} + LEN_W'(2);
                    if (last_rec) ovf_nxt = 1'b1;
                end
            end
            ST_PLAY: begin
                if (stop)      addr_nxt = '0;
                else if (tick) addr_nxt = last_play ? '0 : address + ADDR_W'(1);
            end
            default: addr_nxt = '0;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            address   <= '0;
            length    <= '0;
            overflow  <= 1'b0;
            recording <= 1'b0;
            playing   <= 1'b0;
            done      <= 1'b0;
        end else begin
            address   <= addr_nxt;
            length    <= len_nxt;
            overflow  <= ovf_nxt;
            recording <= (state_nxt == ST_RECORD);
            playing   <= (state_nxt == ST_PLAY);
            done      <= (state_nxt == ST_IDLE) && (len_nxt != '0);
        end
    end

    // Sample RAM is never cleared; length alone marks valid steps
    always_ff @(posedge CLOCK_50) begin
        if (mem_we) mem[mem_waddr] <= ~keys_n;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset || !notes_keep) notes_out <= '0;
        else                      notes_out <= mem[address];
    end

endmodule

// File: tb/tb_record_playback_seq.sv
// Self-checking bench for record_playback_seq against a step-level behavioural model.
module tb_record_playback_seq;

    localparam int CH = 4;
    localparam int DP = 8;
    localparam int TD = 4;

    logic          CLOCK_50 = 1'b0;
    logic          reset = 1'b0;
    logic [CH-1:0] keys_n = '1;
    logic          rec_start = 1'b0;
    logic          play_start = 1'b0;
    logic          stop = 1'b0;
    logic          loop_en = 1'b0;
    logic [CH-1:0] notes_out;
    logic [2:0]    address;
    logic [3:0]    length;
    logic          recording;
    logic          playing;
    logic          done;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    record_playback_seq #(
        .CHANNELS (CH),
        .DEPTH    (DP),
        .TICK_DIV (TD)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .keys_n     (keys_n),
        .rec_start  (rec_start),
        .play_start (play_start),
        .stop       (stop),
        .loop_en    (loop_en),
        .notes_out  (notes_out),
        .address    (address),
        .length     (length),
        .recording  (recording),
        .playing    (playing),
        .done       (done),
        .overflow   (overflow)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Model: phase 0=idle 1=record 2=play; m_cnt = cycles spent in current phase
    int            m_ph = 0;
    int            m_cnt = 0;
    int            m_addr = 0;
    int            m_len = 0;
    bit            m_ovf = 1'b0;
    logic [CH-1:0] m_notes = '0;
    logic [CH-1:0] m_mem [DP];

    wire [14:0] dut_vec = {notes_out, address, length, recording, playing, done, overflow};

    function automatic logic [14:0] exp_vec();
        return {m_notes, 3'(m_addr), 4'(m_len), (m_ph == 1), (m_ph == 2),
                (m_ph == 0) && (m_len != 0), m_ovf};
    endfunction

    task automatic model_edge();
        bit tk;
        int nph;
        int old_addr;
        if (reset) begin
            m_ph = 0; m_cnt = 0; m_addr = 0; m_len = 0; m_ovf = 1'b0; m_notes = '0;
            return;
        end
        tk       = (m_ph != 0) && ((m_cnt % TD) == TD - 1);
        nph      = m_ph;
        old_addr = m_addr;
        case (m_ph)
            0: if (!stop) begin
                if (rec_start) begin
                    nph = 1; m_addr = 0; m_len = 1; m_ovf = 1'b0; m_mem[0] = ~keys_n;
                end else if (play_start && m_len > 0) begin
                    nph = 2; m_addr = 0;
                end
            end
            1: if (stop) nph = 0;
               else if (tk) begin
                   m_addr = m_addr + 1;
                   m_mem[m_addr] = ~keys_n;
                   m_len = m_addr + 1;
                   if (m_addr == DP - 1) begin m_ovf = 1'b1; nph = 0; end
               end
            default: if (stop) begin nph = 0; m_addr = 0; end
               else if (tk) begin
                   if (m_addr < m_len - 1) m_addr = m_addr + 1;
                   else begin m_addr = 0; if (!loop_en) nph = 0; end
               end
        endcase
        m_notes = (m_ph == 2 && nph == 2) ? m_mem[old_addr] : '0;
        m_cnt   = (nph != m_ph) ? 0 : m_cnt + 1;
        m_ph    = nph;
    endtask

    task automatic cyc();
        @(posedge CLOCK_50);
        model_edge();
        #1;
    endtask

    task automatic record_three();
        keys_n = 4'($urandom); rec_start = 1'b1; cyc(); rec_start = 1'b0;
        for (int i = 0; i < 2 * TD; i++) begin keys_n = 4'($urandom); cyc(); end
        stop = 1'b1; cyc(); stop = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; cyc(); cyc(); reset = 1'b0;
        checks++;
        if (dut_vec !== 15'd0) begin
            errors++; $display("FAIL reset_state: got %h expected %h", dut_vec, 15'd0);
        end
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL reset_model: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_record_play_once();
        keys_n = 4'b1110; rec_start = 1'b1; cyc(); rec_start = 1'b0;
        keys_n = 4'b1101;
        for (int i = 0; i < TD; i++) cyc();
        keys_n = 4'b1011;
        for (int i = 0; i < TD; i++) cyc();
        stop = 1'b1; cyc(); stop = 1'b0; keys_n = '1;
        checks++;
        if (length !== 4'd3 || done !== 1'b1) begin
            errors++; $display("FAIL rec_len3: got len=%0d done=%b expected len=3 done=1", length, done);
        end
        loop_en = 1'b0; play_start = 1'b1; cyc(); play_start = 1'b0;
        for (int c = 2; c <= 14; c++) begin
            cyc();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL play_once c%0d: got %h expected %h", c, dut_vec, exp_vec());
            end
            if (c == 2 || c == 6 || c == 10) begin
                logic [3:0] want;
                want = (c == 2) ? 4'b0001 : (c == 6) ? 4'b0010 : 4'b0100;
                checks++;
                if (notes_out !== want) begin
                    errors++; $display("FAIL play_notes c%0d: got %b expected %b", c, notes_out, want);
                end
            end
        end
        checks++;
        if (playing !== 1'b0 || notes_out !== 4'b0 || address !== 3'd0) begin
            errors++; $display("FAIL play_end: got playing=%b notes=%b addr=%0d expected 0,0000,0",
                               playing, notes_out, address);
        end
    endtask

    task automatic test_overflow();
        keys_n = 4'($urandom); rec_start = 1'b1; cyc(); rec_start = 1'b0;
        for (int i = 0; i < (DP - 1) * TD + 2; i++) begin
            keys_n = 4'($urandom); cyc();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL ovf_rec i%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        checks++;
        if (length !== 4'd8 || overflow !== 1'b1 || recording !== 1'b0 || done !== 1'b1) begin
            errors++; $display("FAIL ovf_full: got len=%0d ovf=%b rec=%b expected 8,1,0",
                               length, overflow, recording);
        end
        rec_start = 1'b1; cyc(); rec_start = 1'b0;
        checks++;
        if (overflow !== 1'b0 || recording !== 1'b1 || length !== 4'd1) begin
            errors++; $display("FAIL ovf_clear: got ovf=%b rec=%b len=%0d expected 0,1,1",
                               overflow, recording, length);
        end
        stop = 1'b1; cyc(); stop = 1'b0;
    endtask

    task automatic test_loop_stop();
        record_three();
        loop_en = 1'b1; play_start = 1'b1; cyc(); play_start = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            checks++;
            if (address !== 3'(((c - 1) / TD) % 3) || dut_vec !== exp_vec()) begin
                errors++; $display("FAIL loop_addr c%0d: got %h expected %h (addr %0d)",
                                   c, dut_vec, exp_vec(), ((c - 1) / TD) % 3);
            end
            cyc();
        end
        stop = 1'b1; cyc(); stop = 1'b0;
        checks++;
        if (playing !== 1'b0 || notes_out !== 4'b0 || address !== 3'd0 || length !== 4'd3) begin
            errors++; $display("FAIL loop_stop: got playing=%b notes=%b addr=%0d len=%0d expected 0,0000,0,3",
                               playing, notes_out, address, length);
        end
        loop_en = 1'b0;
    endtask

    task automatic test_idle_commands();
        reset = 1'b1; cyc(); reset = 1'b0;
        play_start = 1'b1; cyc(); cyc(); cyc(); play_start = 1'b0;
        checks++;
        if (playing !== 1'b0 || recording !== 1'b0 || length !== 4'd0) begin
            errors++; $display("FAIL play_empty: got playing=%b rec=%b len=%0d expected 0,0,0",
                               playing, recording, length);
        end
        rec_start = 1'b1; play_start = 1'b1; cyc(); rec_start = 1'b0; play_start = 1'b0;
        checks++;
        if (recording !== 1'b1 || playing !== 1'b0) begin
            errors++; $display("FAIL rec_over_play: got rec=%b playing=%b expected 1,0", recording, playing);
        end
        stop = 1'b1; cyc(); stop = 1'b0;
    endtask

    task automatic test_reset_in_play();
        record_three();
        loop_en = 1'b0; play_start = 1'b1; cyc(); play_start = 1'b0;
        for (int i = 0; i < 2 * TD + 1; i++) cyc();
        checks++;
        if (address !== 3'd2 || playing !== 1'b1) begin
            errors++; $display("FAIL pre_reset_addr: got addr=%0d playing=%b expected 2,1", address, playing);
        end
        reset = 1'b1; play_start = 1'b1; cyc(); reset = 1'b0; play_start = 1'b0;
        checks++;
        if (address !== 3'd0 || length !== 4'd0 || playing !== 1'b0 || notes_out !== 4'b0) begin
            errors++; $display("FAIL reset_in_play: got addr=%0d len=%0d playing=%b notes=%b expected 0,0,0,0000",
                               address, length, playing, notes_out);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            reset      = ($urandom_range(0, 199) == 0);
            stop       = ($urandom_range(0, 39) == 0);
            rec_start  = ($urandom_range(0, 24) == 0);
            play_start = ($urandom_range(0, 9) == 0);
            loop_en    = 1'($urandom);
            keys_n     = 4'($urandom);
            cyc();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL random i%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        reset = 1'b0; stop = 1'b0; rec_start = 1'b0; play_start = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_record_play_once();
        test_overflow();
        test_loop_stop();
        test_idle_commands();
        test_reset_in_play();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
